// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker state encoding, default parameters and
// the polynomial mask table used by both the generator and the checker.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_UNSUP  = 2'd0,
    ST_SEED   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } lfsr_state_e;

  localparam int LOCK_MATCHES_DEF = 8;
  localparam int LOSS_MISSES_DEF  = 4;
  localparam int CNT_W_DEF        = 16;

  // Returns {valid, mask[7:0]}; unsupported combinations give valid = 0.
  function automatic logic [8:0] lfsr_mask(input logic [2:0] length, input logic n_taps);
    logic [8:0] r;
    r = 9'h000;
    if (!n_taps) begin
      case (length)
        3'd2:    r = {1'b1, 8'h03};
        3'd3:    r = {1'b1, 8'h06};
        3'd4:    r = {1'b1, 8'h0C};
        3'd5:    r = {1'b1, 8'h14};
        3'd6:    r = {1'b1, 8'h30};
        3'd7:    r = {1'b1, 8'h60};
        default: r = 9'h000;
      endcase
    end else begin
      case (length)
        3'd5:    r = {1'b1, 8'h1E};
        3'd6:    r = {1'b1, 8'h36};
        3'd7:    r = {1'b1, 8'h78};
        default: r = 9'h000;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_sequence_checker_mask.sv
// Combinational polynomial mask lookup for the current configuration.
module lfsr_mask_lookup
  import lfsr_pkg::*;
(
  input  logic [2:0] length,
  input  logic       n_taps,
  output logic       valid,
  output logic [7:0] mask
);

  // Decode the configuration into a tap mask and a validity flag
  always_comb begin
    {valid, mask} = lfsr_mask(length, n_taps);
  end

endmodule

// File: rtl/lfsr_sequence_checker.sv
// Self-synchronising Fibonacci LFSR sequence checker: seeds its history from
// the received stream, verifies a run of predictions, then flywheels on its
// own predictions while counting mismatches until lock is lost.
module lfsr_sequence_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_MATCHES = LOCK_MATCHES_DEF,
  parameter int LOSS_MISSES  = LOSS_MISSES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       lfsr_length,
  input  logic             lfsr_n_taps,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             clr_counts,
  output logic             locked,
  output logic             cfg_err,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic [1:0]       state
);

  localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam int MISS_W  = $clog2(LOSS_MISSES + 1);

  logic               cfg_valid;
  logic [7:0]         mask;
  logic [3:0]         cfg_cur, cfg_q;
  lfsr_state_e        state_q, state_d;
  logic [7:0]         sr_q, sr_d;
  logic [2:0]         seed_cnt_q, seed_cnt_d, seed_next;
  logic [MATCH_W-1:0] match_q, match_d, match_inc;
  logic [MISS_W-1:0]  miss_q, miss_d, miss_inc;
  logic               err_pulse_q, err_pulse_d, cfg_err_q;
  logic [CNT_W-1:0]   err_cnt_q, bit_cnt_q;
  logic               err_inc, bit_inc;
  logic               pred;
  logic [7:0]         win_mask, sr_in;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  lfsr_mask_lookup u_mask (
    .length (lfsr_length),
    .n_taps (lfsr_n_taps),
    .valid  (cfg_valid),
    .mask   (mask)
  );

  assign cfg_cur   = {lfsr_n_taps, lfsr_length};
  assign pred      = ^(sr_q & mask);
  assign sr_in     = {sr_q[6:0], in_bit};
  assign win_mask  = 8'hFF >> (4'd8 - {1'b0, lfsr_length});
  // seed_cnt holds at length so a zero window keeps re-checking without wrapping
  assign seed_next = (seed_cnt_q >= lfsr_length) ? seed_cnt_q : seed_cnt_q + 3'd1;
  assign match_inc = match_q + MATCH_W'(1);
  assign miss_inc  = miss_q + MISS_W'(1);

  // Next-state, history and counter-increment decisions for one beat
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    seed_cnt_d  = seed_cnt_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    bit_inc     = 1'b0;
    if (cfg_cur != cfg_q) begin
      state_d    = cfg_valid ? ST_SEED : ST_UNSUP;
      sr_d       = '0;
      seed_cnt_d = '0;
      match_d    = '0;
      miss_d     = '0;
    end else begin
      case (state_q)
        ST_UNSUP: begin
          if (cfg_valid) begin
            state_d    = ST_SEED;
            sr_d       = '0;
            seed_cnt_d = '0;
            match_d    = '0;
            miss_d     = '0;
          end
        end
        ST_SEED: begin
          if (in_valid) begin
            sr_d       = sr_in;
            seed_cnt_d = seed_next;
            // an all-zero window is never produced by the generator
            if ((seed_next >= lfsr_length) && ((sr_in & win_mask) != 8'd0)) begin
              state_d = ST_VERIFY;
              match_d = '0;
            end
          end
        end
        ST_VERIFY: begin
          if (in_valid) begin
            sr_d = sr_in;
            if (in_bit == pred) begin
              match_d = match_inc;
              if (match_inc == MATCH_W'(LOCK_MATCHES)) begin
                state_d = ST_LOCKED;
                miss_d  = '0;
              end
            end else begin
              state_d    = ST_SEED;
              seed_cnt_d = '0;
              match_d    = '0;
            end
          end
        end
        default: begin
          if (in_valid) begin
            // flywheel: history follows our own prediction, not the line
            sr_d    = {sr_q[6:0], pred};
            bit_inc = 1'b1;
            if (in_bit != pred) begin
              err_pulse_d = 1'b1;
              err_inc     = 1'b1;
              miss_d      = miss_inc;
              if (miss_inc == MISS_W'(LOSS_MISSES)) begin
                state_d    = ST_SEED;
                seed_cnt_d = '0;
                match_d    = '0;
                miss_d     = '0;
              end
            end else begin
              miss_d = '0;
            end
          end
        end
      endcase
    end
  end

  // State, history and saturating counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= cfg_valid ? ST_SEED : ST_UNSUP;
      cfg_q       <= cfg_cur;
      sr_q        <= '0;
      seed_cnt_q  <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      err_pulse_q <= 1'b0;
      cfg_err_q   <= ~cfg_valid;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_cur;
      sr_q        <= sr_d;
      seed_cnt_q  <= seed_cnt_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_pulse_q <= err_pulse_d;
      cfg_err_q   <= ~cfg_valid;
      if (clr_counts) begin
        err_cnt_q <= '0;
        bit_cnt_q <= '0;
      end else begin
        if (err_inc) err_cnt_q <= sat_inc(err_cnt_q);
        if (bit_inc) bit_cnt_q <= sat_inc(bit_cnt_q);
      end
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign state     = state_q;
  assign cfg_err   = cfg_err_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;
  assign bit_count = bit_cnt_q;

endmodule
